// File: rtl/arbiter_pkg.sv
// arbiter_pkg: shared definitions for the weighted round-robin arbiter.
//   arb_state_t  - arbiter state encoding (IDLE=0, OWN=1)
//   sel_w()      - index width for a port count, never less than 1 bit
//   eff_weight() - burst credit for a programmed weight (0 behaves as 1)
package arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_t;

  // $clog2(1) is 0, which would give a zero-width select; clamp to 1.
  function automatic int sel_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // A zero weight would otherwise produce a grant that could never
  // retire through done; give it a single-transfer burst instead.
  function automatic int unsigned eff_weight(input int unsigned w);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational rotating-priority picker.
//   req    in  NUM_PORTS - request vector
//   base   in  SEL_W     - highest-priority index (must be < NUM_PORTS)
//   hit    out 1         - any request set
//   idx    out SEL_W     - first set bit at or above base, wrapping; 0 if none
//   onehot out NUM_PORTS - idx as one-hot; 0 if none
module rr_pick
  import arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 6,
  parameter int SEL_W     = sel_w(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [SEL_W-1:0]     base,
  output logic                 hit,
  output logic [SEL_W-1:0]     idx,
  output logic [NUM_PORTS-1:0] onehot
);

  localparam int SW1 = SEL_W + 1;

  logic [2*NUM_PORTS-1:0] dbl;
  logic [NUM_PORTS-1:0]   rot;
  logic [SEL_W:0]         off;
  logic [SEL_W:0]         sum;

  always_comb begin
    // Two copies back to back: shifting right by base leaves the
    // wrapped window req[base..N-1], req[0..base-1] in the low N bits.
    dbl = {req, req} >> base;
    rot = dbl[NUM_PORTS-1:0];
    hit = |rot;

    // Lowest set bit of the rotated window is the winner's offset.
    off = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (rot[i]) off = SW1'(i);
    end

    // Undo the rotation; one extra bit keeps base+off from overflowing.
    sum = {1'b0, base} + off;
    if (sum >= SW1'(NUM_PORTS)) sum = sum - SW1'(NUM_PORTS);

    idx    = hit ? sum[SEL_W-1:0] : '0;
    onehot = '0;
    if (hit) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/wrr_arbiter.sv
// wrr_arbiter: weighted round-robin bus arbiter with burst credits.
// An owner keeps the bus for up to weight[p] completed transfers (done
// pulses) or until it drops its request; the next owner is chosen in the
// release cycle so handover costs no idle cycle.
//   clk     in  1                  - clock, rising edge
//   rst_n   in  1                  - async active-low reset
//   request in  NUM_PORTS          - per-master request, held while in use
//   weight  in  NUM_PORTS*WEIGHT_W - per-port burst length (0 acts as 1)
//   done    in  1                  - owner finished one transfer this cycle
//   grant   out NUM_PORTS          - one-hot owner, 0 when idle
//   select  out SEL_W              - owner index, 0 when idle
//   active  out 1                  - bus owned
module wrr_arbiter
  import arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 6,
  parameter int WEIGHT_W  = 4,
  parameter int SEL_W     = sel_w(NUM_PORTS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_PORTS-1:0]          request,
  input  logic [NUM_PORTS*WEIGHT_W-1:0] weight,
  input  logic                          done,
  output logic [NUM_PORTS-1:0]          grant,
  output logic [SEL_W-1:0]              select,
  output logic                          active
);

  arb_state_t state;

  logic [NUM_PORTS-1:0][WEIGHT_W-1:0] wt;
  logic [SEL_W-1:0]     ptr;
  logic [WEIGHT_W-1:0]  credit;
  logic [SEL_W-1:0]     nxt_base;
  logic [SEL_W-1:0]     base;
  logic                 rel;
  logic                 pick_hit;
  logic [SEL_W-1:0]     pick_idx;
  logic [NUM_PORTS-1:0] pick_oh;
  logic [WEIGHT_W-1:0]  load_credit;

  assign wt = weight;

  always_comb begin
    // Port after the current owner, wrapping at NUM_PORTS.
    nxt_base = (select == SEL_W'(NUM_PORTS - 1)) ? '0 : select + 1'b1;
    base     = (state == IDLE) ? ptr : nxt_base;
    // Request drop and last-credit done in the same cycle are one release.
    rel      = (state == OWN) &&
               (!request[select] || (done && credit == WEIGHT_W'(1)));
    load_credit = WEIGHT_W'(eff_weight(32'(wt[pick_idx])));
  end

  // Searching from owner+1 over the full request vector naturally places
  // the releasing port last, so it only re-wins when nobody else asks.
  rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .SEL_W     (SEL_W)
  ) u_pick (
    .req    (request),
    .base   (base),
    .hit    (pick_hit),
    .idx    (pick_idx),
    .onehot (pick_oh)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      grant  <= '0;
      select <= '0;
      active <= 1'b0;
      ptr    <= '0;
      credit <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_hit) begin
            state  <= OWN;
            grant  <= pick_oh;
            select <= pick_idx;
            active <= 1'b1;
            credit <= load_credit;
          end
        end
        OWN: begin
          if (rel) begin
            ptr <= nxt_base;
            if (pick_hit) begin
              grant  <= pick_oh;
              select <= pick_idx;
              credit <= load_credit;
            end else begin
              state  <= IDLE;
              grant  <= '0;
              select <= '0;
              active <= 1'b0;
              credit <= '0;
            end
          end else if (done && credit != '0) begin
            credit <= credit - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wrr_arbiter.sv
// Directed bench for wrr_arbiter: each step drives inputs, pushes the
// expected owner (-1 = idle) to a scoreboard, and pops/compares after the
// following rising edge.
module tb_wrr_arbiter;

  localparam int N  = 6;
  localparam int WW = 4;
  localparam int SW = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      request = '0;
  logic [N-1:0][WW-1:0] wt = '0;
  logic              done = 1'b0;
  logic [N-1:0]      grant;
  logic [SW-1:0]     select;
  logic              active;

  int checks = 0;
  int errors = 0;

  int    exp_q[$];
  string tag_q[$];

  wrr_arbiter #(.NUM_PORTS(N), .WEIGHT_W(WW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .request (request),
    .weight  (wt),
    .done    (done),
    .grant   (grant),
    .select  (select),
    .active  (active)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check_outs(input int o, input string tag);
    logic [N-1:0]  eg;
    logic [SW-1:0] es;
    logic          ea;
    eg = '0;
    es = '0;
    ea = 1'b0;
    if (o >= 0) begin
      eg[o] = 1'b1;
      es    = SW'(o);
      ea    = 1'b1;
    end
    checks++;
    assert (grant === eg) else begin
      errors++;
      $error("FAIL %s grant got %b exp %b", tag, grant, eg);
    end
    checks++;
    assert (select === es) else begin
      errors++;
      $error("FAIL %s select got %0d exp %0d", tag, select, es);
    end
    checks++;
    assert (active === ea) else begin
      errors++;
      $error("FAIL %s active got %b exp %b", tag, active, ea);
    end
  endtask

  task automatic check_ptr(input int e, input string tag);
    checks++;
    assert (int'(dut.ptr) === e) else begin
      errors++;
      $error("FAIL %s ptr got %0d exp %0d", tag, dut.ptr, e);
    end
  endtask

  // Drive one cycle of stimulus; o is the owner expected after the edge.
  task automatic step(input logic [N-1:0] r, input logic d, input int o,
                      input string tag);
    int    eo;
    string et;
    request = r;
    done    = d;
    exp_q.push_back(o);
    tag_q.push_back(tag);
    @(posedge clk);
    @(negedge clk);
    eo = exp_q.pop_front();
    et = tag_q.pop_front();
    check_outs(eo, et);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    request = '0;
    done    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state, checked before any clock edge matters.
    #2;
    check_outs(-1, "reset");
    check_ptr(0, "reset_ptr");
    @(negedge clk);
    rst_n = 1'b1;

    // Single port, burst of 3 then re-win with no idle gap.
    wt[2] = 4'd3;
    step(6'b000100, 1'b0, 2, "single_grant");
    step(6'b000100, 1'b1, 2, "single_d1");
    step(6'b000100, 1'b1, 2, "single_d2");
    step(6'b000100, 1'b1, 2, "single_rewin");
    step(6'b000100, 1'b1, 2, "single_after");
    step(6'b000000, 1'b0, -1, "single_drop");
    check_ptr(3, "single_ptr");

    // Weighted rotation from a fresh reset.
    do_reset();
    wt = '0;
    wt[0] = 4'd1; wt[1] = 4'd2; wt[2] = 4'd3;
    wt[3] = 4'd1; wt[4] = 4'd1; wt[5] = 4'd2;
    begin
      int seq[12] = '{0, 1, 1, 2, 2, 2, 3, 4, 5, 5, 0, 1};
      foreach (seq[i]) step(6'b111111, 1'b1, seq[i], $sformatf("rot%0d", i));
    end
    step(6'b000000, 1'b0, -1, "rot_idle");
    check_ptr(2, "rot_ptr");

    // Early release: port 1 (weight 5) drops after two transfers.
    wt[1] = 4'd5;
    wt[4] = 4'd2;
    step(6'b000010, 1'b0, 1, "early_grant");
    step(6'b010010, 1'b1, 1, "early_d1");
    step(6'b010010, 1'b1, 1, "early_d2");
    step(6'b010000, 1'b0, 4, "early_handover");
    check_ptr(2, "early_ptr");
    step(6'b000000, 1'b0, -1, "early_idle");
    check_ptr(5, "early_ptr2");

    // Simultaneous drop + last done, and zero weights.
    wt[0] = 4'd0;
    wt[3] = 4'd0;
    step(6'b001001, 1'b0, 0, "sim_grant0");
    step(6'b001000, 1'b1, 3, "sim_single_rel");
    check_ptr(1, "sim_ptr");
    step(6'b001001, 1'b1, 0, "w0_port3");
    check_ptr(4, "w0_ptr");
    step(6'b001001, 1'b1, 3, "w0_port0");
    step(6'b000000, 1'b0, -1, "sim_idle");

    // Wrap and idle: port 5 alone, then ports 0 and 5.
    wt[5] = 4'd2;
    step(6'b100000, 1'b0, 5, "wrap_grant5");
    step(6'b100000, 1'b1, 5, "wrap_d1");
    step(6'b000000, 1'b0, -1, "wrap_idle");
    check_ptr(0, "wrap_ptr");
    step(6'b100001, 1'b0, 0, "wrap_p0_wins");

    // Port 0 leaves, port 5 takes over (ptr becomes 1), then async reset.
    step(6'b100000, 1'b0, 5, "ar_handover");
    check_ptr(1, "ar_ptr_pre");
    #2;
    rst_n = 1'b0;
    #1;
    check_outs(-1, "async_reset");
    check_ptr(0, "async_ptr");
    @(negedge clk);
    rst_n = 1'b1;
    step(6'b100001, 1'b0, 0, "ar_restart_p0");
    step(6'b000000, 1'b0, -1, "ar_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
